// File: rtl/exp5_unidade_controle.sv
// Moore control unit for the exp5 memory game: sequences counter, switch register
// and comparator through each play, and reports win / wrong play / timeout.
module exp5_unidade_controle #(
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       chavesIgualMemoria,
   input  logic       fimC,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [3:0] db_estado
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      INICIAL       = 4'b0000,
      PREPARACAO    = 4'b0001,
      ESPERA_JOGADA = 4'b0010,
      REGISTRA      = 4'b0100,
      COMPARACAO    = 4'b0101,
      PROXIMO       = 4'b0110,
      FIM_ACERTOU   = 4'b1010,
      FIM_ERROU     = 4'b1110,
      FIM_TIMEOUT   = 4'b1101
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic            r_jogada_d;
   logic [TW-1:0]   r_tcount;
   logic [TW-1:0]   w_tcount_next;
   logic            w_jogada_edge;

   assign w_jogada_edge = jogada & ~r_jogada_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= INICIAL;
         r_jogada_d <= 1'b0;
         r_tcount   <= '0;
      end else begin
         r_state    <= w_state_next;
         r_jogada_d <= jogada;
         r_tcount   <= w_tcount_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_tcount_next = '0;
      zeraC         = 1'b0;
      contaC        = 1'b0;
      zeraR         = 1'b0;
      registraR     = 1'b0;
      pronto        = 1'b0;
      acertou       = 1'b0;
      errou         = 1'b0;
      timeout       = 1'b0;
      case (r_state)
         INICIAL: begin
            if (iniciar) w_state_next = PREPARACAO;
         end
         PREPARACAO: begin
            zeraC        = 1'b1;
            zeraR        = 1'b1;
            w_state_next = ESPERA_JOGADA;
         end
         ESPERA_JOGADA: begin
            // A play on the last allowed cycle still counts.
            if (w_jogada_edge) begin
               w_state_next = REGISTRA;
            end else if (r_tcount == T_LAST) begin
               w_state_next = FIM_TIMEOUT;
            end else begin
               w_tcount_next = r_tcount + 1'b1;
            end
         end
         REGISTRA: begin
            registraR    = 1'b1;
            w_state_next = COMPARACAO;
         end
         COMPARACAO: begin
            if (!chavesIgualMemoria) w_state_next = FIM_ERROU;
            else if (fimC)           w_state_next = FIM_ACERTOU;
            else                     w_state_next = PROXIMO;
         end
         PROXIMO: begin
            contaC       = 1'b1;
            w_state_next = ESPERA_JOGADA;
         end
         FIM_ACERTOU: begin
            pronto  = 1'b1;
            acertou = 1'b1;
            if (iniciar) w_state_next = PREPARACAO;
         end
         FIM_ERROU: begin
            pronto = 1'b1;
            errou  = 1'b1;
            if (iniciar) w_state_next = PREPARACAO;
         end
         FIM_TIMEOUT: begin
            pronto  = 1'b1;
            timeout = 1'b1;
            if (iniciar) w_state_next = PREPARACAO;
         end
         default: w_state_next = INICIAL;
      endcase
   end

   assign db_estado = r_state;

endmodule

// File: tb/tb_exp5_unidade_controle.sv
// Directed bench for exp5_unidade_controle with a short timeout (8 cycles);
// each check compares {db_estado, control/result outputs} against a hand-made constant.
module tb_exp5_unidade_controle;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       iniciar = 1'b0;
   logic       jogada = 1'b0;
   logic       chavesIgualMemoria = 1'b0;
   logic       fimC = 1'b0;
   logic       zeraC, contaC, zeraR, registraR;
   logic       pronto, acertou, errou, timeout;
   logic [3:0] db_estado;

   int n_checks = 0;
   int n_fail   = 0;
   int n_conta  = 0;
   int n_espera;

   // {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
   localparam logic [11:0] E_INI  = 12'h000;
   localparam logic [11:0] E_PREP = 12'h1A0;
   localparam logic [11:0] E_ESP  = 12'h200;
   localparam logic [11:0] E_REG  = 12'h410;
   localparam logic [11:0] E_CMP  = 12'h500;
   localparam logic [11:0] E_PROX = 12'h640;
   localparam logic [11:0] E_ACE  = 12'hA0C;
   localparam logic [11:0] E_ERR  = 12'hE0A;
   localparam logic [11:0] E_TMO  = 12'hD09;

   logic [11:0] w_obs;
   assign w_obs = {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};

   exp5_unidade_controle #(.TIMEOUT_CYCLES(8)) dut (
      .clock              (clock),
      .reset              (reset),
      .iniciar            (iniciar),
      .jogada             (jogada),
      .chavesIgualMemoria (chavesIgualMemoria),
      .fimC               (fimC),
      .zeraC              (zeraC),
      .contaC             (contaC),
      .zeraR              (zeraR),
      .registraR          (registraR),
      .pronto             (pronto),
      .acertou            (acertou),
      .errou              (errou),
      .timeout            (timeout),
      .db_estado          (db_estado)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      if (contaC) n_conta++;
   endtask

   task automatic count_espera();
      n_espera = 0;
      while (db_estado == 4'b0010 && n_espera < 20) begin
         n_espera++;
         tick();
      end
   endtask

   initial begin
      // 1: reset, start, initialisation pulse
      tick(); check("reset_c1", w_obs, E_INI);
      tick(); check("reset_c2", w_obs, E_INI);
      reset = 1'b0;
      tick(); check("idle", w_obs, E_INI);
      iniciar = 1'b1;
      tick(); check("prep", w_obs, E_PREP);
      iniciar = 1'b0;
      tick(); check("espera0", w_obs, E_ESP);

      // 2: held jogada yields exactly one play
      jogada = 1'b1; chavesIgualMemoria = 1'b1; fimC = 1'b0;
      tick(); check("p1_reg", w_obs, E_REG);
      tick(); check("p1_cmp", w_obs, E_CMP);
      tick(); check("p1_prox", w_obs, E_PROX);
      tick(); check("p1_esp", w_obs, E_ESP);
      tick(); check("held_no_reg", w_obs, E_ESP);
      jogada = 1'b0;
      tick(); check("release", w_obs, E_ESP);

      // 3: wrong play, held result, restart
      jogada = 1'b1; chavesIgualMemoria = 1'b0;
      tick(); check("e_reg", w_obs, E_REG);
      jogada = 1'b0;
      tick(); check("e_cmp", w_obs, E_CMP);
      tick(); check("errou", w_obs, E_ERR);
      for (int i = 0; i < 10; i++) tick();
      check("errou_held", w_obs, E_ERR);
      iniciar = 1'b1;
      tick(); check("restart_prep", w_obs, E_PREP);
      iniciar = 1'b0;
      tick(); check("restart_esp", w_obs, E_ESP);

      // 4: sixteen correct plays
      n_conta = 0;
      chavesIgualMemoria = 1'b1;
      for (int p = 0; p < 16; p++) begin
         fimC = (p == 15);
         jogada = 1'b1;
         tick();
         jogada = 1'b0;
         tick();
         tick();
         if (p < 15) tick();
      end
      check("win_state", w_obs, E_ACE);
      check("conta_pulses", n_conta, 15);
      fimC = 1'b0;

      // 5a: timeout after exactly 8 cycles of waiting
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      tick();
      count_espera();
      check("tmo_cycles", n_espera, 8);
      check("tmo_state", w_obs, E_TMO);

      // 5b: play on the final allowed cycle wins
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      tick();
      for (int i = 0; i < 7; i++) tick();
      check("last_cycle_esp", w_obs, E_ESP);
      jogada = 1'b1;
      tick(); check("last_cycle_reg", w_obs, E_REG);
      jogada = 1'b0;
      tick(); check("lc_cmp", w_obs, E_CMP);
      tick(); check("lc_prox", w_obs, E_PROX);

      // 6: reset in proximo, restart with fresh timeout count
      reset = 1'b1;
      tick(); check("rst_prox", w_obs, E_INI);
      reset = 1'b0;
      tick(); check("rst_prox_idle", w_obs, E_INI);
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      tick();
      count_espera();
      check("tmo_after_rst", n_espera, 8);
      check("tmo_after_rst_st", w_obs, E_TMO);

      // reset wins over iniciar
      iniciar = 1'b1; reset = 1'b1;
      tick(); check("rst_vs_ini", w_obs, E_INI);
      reset = 1'b0;
      tick(); check("ini_after_rst", w_obs, E_PREP);
      iniciar = 1'b0;
      tick();

      // reset in registra
      jogada = 1'b1;
      tick(); check("pre_rst_reg", w_obs, E_REG);
      reset = 1'b1; jogada = 1'b0;
      tick(); check("rst_reg", w_obs, E_INI);
      reset = 1'b0;
      tick(); check("rst_reg_idle", w_obs, E_INI);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exp5_unidade_controle.md
Name: exp5_unidade_controle

Overview:
Moore FSM that sequences the exp5 memory-game datapath: the address counter (zeraC/contaC/fimC), the switch register (zeraR/registraR) and the switch-vs-memory comparator (chavesIgualMemoria). It waits for `iniciar` and initialises the datapath. For each play (rising edge of `jogada`) it registers the switches, compares them against memory, and then advances, wins, loses or times out. It sits beside exp4_fluxo_dados in the exp5 top level.

Parameters:
TIMEOUT_CYCLES, 5000, number of clock cycles allowed in espera_jogada before timeout (≥2); benches override to 8.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
iniciar  input  1  start/restart request (level, sampled each edge)
jogada  input  1  any switch pressed (level; internally edge-detected)
chavesIgualMemoria  input  1  comparator result from datapath
fimC  input  1  counter at last address (15)
zeraC  output  1  clear address counter
contaC  output  1  increment address counter
zeraR  output  1  clear switch register
registraR  output  1  load switch register
pronto  output  1  game ended (any final state)
acertou  output  1  all 16 plays correct
errou  output  1  wrong play
timeout  output  1  play not made in time
db_estado  output  4  current state encoding (debug/HEX)

Behaviour:
- One clock, `clock`. Reset is synchronous and active-high on `reset`. On reset: state=inicial, jogada_d=0, timeout counter=0.
- Outputs during reset and in inicial: all 0; db_estado=0000.
- All outputs are Moore, decoded from the state register only.
- Edge detect: jogada_d <= jogada every edge; jogada_edge = jogada & ~jogada_d.
  - A held jogada produces exactly one edge.
  - The edge is evaluated in every state but consumed only in espera_jogada.
- States (db_estado), outputs, transitions:
  - inicial (0000), outputs none: iniciar=1 -> preparacao, else stay.
  - preparacao (0001), zeraC=1, zeraR=1: -> espera_jogada unconditionally.
  - espera_jogada (0010), outputs none:
    - jogada_edge=1 -> registra.
    - else if tcount==TIMEOUT_CYCLES-1 -> fim_timeout.
    - else stay, tcount+1.
  - registra (0100), registraR=1: -> comparacao.
  - comparacao (0101), outputs none:
    - igual=0 -> fim_errou.
    - else fimC=1 -> fim_acertou.
    - else -> proximo.
  - proximo (0110), contaC=1: -> espera_jogada.
  - fim_acertou (1010), pronto=1, acertou=1.
  - fim_errou (1110), pronto=1, errou=1.
  - fim_timeout (1101), pronto=1, timeout=1.
  - Any fim_* state: iniciar=1 -> preparacao, else stay (results held).
  - Unused encodings -> inicial.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES).
  - Cleared in every cycle the state is not espera_jogada, so each entry starts at 0.
  - Exactly TIMEOUT_CYCLES cycles are spent in espera_jogada before fim_timeout.
  - No wrap-around is possible.
- Simultaneous events:
  - jogada_edge on the final timeout cycle: the play wins, next state registra.
  - iniciar is ignored outside inicial and fim_*.
  - iniciar and reset together: reset wins.
- Latency:
  - iniciar high at edge k -> preparacao after k -> espera_jogada after k+1.
  - jogada rising before edge k -> registra after k, comparacao after k+1, decision state after k+2.
- Reset mid-operation (any state): inicial on the same edge; all outputs 0 the following cycle; no partial contaC/registraR pulse.

Test Plan:
1. reset=1 for 2 cycles, then iniciar pulse of 1 cycle -> db_estado 0000->0001->0010; zeraC=zeraR=1 for exactly one cycle; other outputs 0.
2. In espera, jogada held high 5 cycles, igual=1, fimC=0 -> registraR 1 cycle, comparacao, contaC 1 cycle, back to 0010; no second registraR while jogada stays high.
3. In espera, jogada edge with igual=0 -> db_estado=1110, errou=1, pronto=1 held for 10 cycles; iniciar pulse -> 0001, errou=0.
4. 16 correct plays with fimC=1 on the 16th comparacao -> contaC pulses exactly 15 times; final db_estado=1010, acertou=1, pronto=1.
5. TIMEOUT_CYCLES=8, no jogada -> exactly 8 cycles in 0010, then 1101 with timeout=1. Rerun with the jogada edge in the 8th cycle -> 0100, no timeout.
6. reset asserted while in registra and while in proximo -> next cycle db_estado=0000, all outputs 0; a new iniciar restarts normally with tcount starting at 0.
